line_clear_engine: RTL and testbench
====================================

# line_clear_engine

Row-clear controller for the playfield grid memory. On a start pulse it scans the grid bottom-up for full rows. Each full row is removed by shifting every row above it down one position and zero-filling the top row. The block drives the grid memory's port B (read) and port A (write), and reports the number of rows cleared to the scoring/game-control logic.

## Interface
- DATA_WIDTH, 8: row width in cells; one grid word is one row, one bit per column (1 = occupied).
- ADDR_WIDTH, 8: grid memory address width.
- ROWS, 20: playfield rows; row 0 is the top, row ROWS-1 is the bottom. ROWS must be ≤ 2**ADDR_WIDTH.
- CNT_WIDTH, 5: lines_cleared width. ROWS must be ≤ 2**CNT_WIDTH-1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset: synchronous and active-low.
- start  in  1  one-cycle request to run a clear pass; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of pass.
- lines_cleared  out  CNT_WIDTH  rows cleared by the most recent pass.
- mem_addr_b  out  ADDR_WIDTH  grid read address.
- mem_q_b  in  DATA_WIDTH  grid read data; registered, valid one cycle after mem_addr_b.
- mem_addr_a  out  ADDR_WIDTH  grid write address.
- mem_data_a  out  DATA_WIDTH  grid write data.
- mem_we_a  out  1  grid write enable.

## Operation
- A row is full when mem_q_b is all ones across DATA_WIDTH bits.
- Registers:
  - row: the row being scanned.
  - dst: the shift destination.
  - cnt: drives lines_cleared.
- States and transitions:
  - IDLE: if start, then row ← ROWS-1, cnt ← 0, go to RD. Otherwise stay.
  - RD: mem_addr_b = row; go to CHK.
  - CHK: evaluate mem_q_b.
    - Full and row > 0: dst ← row, go to SH_RD.
    - Full and row == 0: go to CLR_TOP.
    - Not full and row > 0: row ← row-1, go to RD.
    - Not full and row == 0: go to DONE.
  - SH_RD: mem_addr_b = dst-1; go to SH_WR.
  - SH_WR: mem_we_a = 1, mem_addr_a = dst, mem_data_a = mem_q_b.
    - If dst == 1, go to CLR_TOP.
    - Otherwise dst ← dst-1, go to SH_RD.
  - CLR_TOP: mem_we_a = 1, mem_addr_a = 0, mem_data_a = 0, cnt ← cnt+1, then go to RD.
    - row is unchanged, so the same row is rescanned; this catches a full row that has just shifted down into it.
  - DONE: done = 1; go to IDLE.
- Output defaults:
  - mem_we_a = 0 outside SH_WR and CLR_TOP.
  - mem_addr_a and mem_data_a are 0 when not writing.
  - mem_addr_b holds its last value when not reading.
- start is ignored while busy.
- lines_cleared holds its value after done until the next accepted start.
- Address arithmetic is unsigned ADDR_WIDTH and never wraps: row and dst are never decremented below 0.

## Timing
- Reset (rst_n low at a rising edge) gives:
  - state IDLE;
  - busy = 0, done = 0;
  - lines_cleared = 0;
  - mem_we_a = 0;
  - mem_addr_a = 0, mem_addr_b = 0, mem_data_a = 0.
- Reset mid-pass aborts immediately. Writes already performed remain in memory; no write occurs in the reset cycle.
- All outputs are Moore, decoded from registered state.
- Cycle counts:
  - Scanning a non-full row costs 2 cycles (RD, CHK).
  - Clearing a full row at index r > 0 costs 2r + 1 cycles (r shift pairs plus CLR_TOP), followed by a 2-cycle rescan of r.
  - Clearing a full row at index 0 costs 1 cycle, followed by a 2-cycle rescan.
- A pass with no full rows: busy is high for 2·ROWS + 1 cycles; done is high in the last of them.
- The read-after-write hazard does not occur: SH_RD always reads dst-1, which is not written until a later SH_WR.

## Test plan
- Empty grid, start pulse.
  - Required: no writes, lines_cleared = 0.
  - Required: busy high for exactly 41 cycles (ROWS=20), done on the 41st.
- Row 19 = 0xFF, row 18 = 0x81, others 0.
  - Required: after done, row 19 = 0x81, rows 0–18 = 0, lines_cleared = 1.
- Rows 16–19 all 0xFF, row 15 = 0x3C.
  - Required: row 19 = 0x3C, rows 0–18 = 0, lines_cleared = 4.
- Only row 0 = 0xFF.
  - Required: a single write of 0 to address 0, lines_cleared = 1, no other writes.
- Start pulsed again while busy.
  - Required: ignored; pass result and cycle count are identical to a single start.
- rst_n low during SH_WR of a clear.
  - Required: the next cycle shows IDLE, all outputs 0, and the write for that cycle is suppressed.
  - Required: a following start completes a normal pass.

Source files
------------

// File: rtl/line_clear_engine.sv
// Row-clear controller for the playfield grid memory: scans bottom-up, removes
// full rows by shifting everything above them down one row and zero-filling row 0.
module line_clear_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int ROWS       = 20,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [CNT_WIDTH-1:0]  o_lines_cleared,
    output logic [ADDR_WIDTH-1:0] o_mem_addr_b,
    input  logic [DATA_WIDTH-1:0] i_mem_q_b,
    output logic [ADDR_WIDTH-1:0] o_mem_addr_a,
    output logic [DATA_WIDTH-1:0] o_mem_data_a,
    output logic                  o_mem_we_a
);

    // state   | meaning
    // IDLE    | waiting for start
    // RD      | read address = row
    // CHK     | test row data for full
    // SH_RD   | read address = dst-1
    // SH_WR   | write row dst-1 into dst
    // CLR_TOP | zero row 0, count the cleared line, rescan row
    // DONE    | one-cycle done pulse
    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_CHK, S_SH_RD, S_SH_WR, S_CLR_TOP, S_DONE
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_row, w_row_nxt;
    logic [ADDR_WIDTH-1:0] r_dst, w_dst_nxt;
    logic [CNT_WIDTH-1:0]  r_cnt, w_cnt_nxt;
    logic [ADDR_WIDTH-1:0] r_addr_b_hold;
    logic                  w_full;

    assign w_full = &i_mem_q_b;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_row         <= '0;
            r_dst         <= '0;
            r_cnt         <= '0;
            r_addr_b_hold <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_row         <= w_row_nxt;
            r_dst         <= w_dst_nxt;
            r_cnt         <= w_cnt_nxt;
            r_addr_b_hold <= o_mem_addr_b;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_row_nxt       = r_row;
        w_dst_nxt       = r_dst;
        w_cnt_nxt       = r_cnt;
        o_mem_addr_b    = r_addr_b_hold;
        o_mem_addr_a    = '0;
        o_mem_data_a    = '0;
        o_mem_we_a      = 1'b0;
        o_done          = 1'b0;
        o_busy          = (r_state != S_IDLE);
        o_lines_cleared = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_row_nxt   = ADDR_WIDTH'(ROWS - 1);
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RD;
                end
            end
            S_RD: begin
                o_mem_addr_b = r_row;
                w_state_nxt  = S_CHK;
            end
            S_CHK: begin
                if (w_full) begin
                    if (r_row != '0) begin
                        w_dst_nxt   = r_row;
                        w_state_nxt = S_SH_RD;
                    end else begin
                        w_state_nxt = S_CLR_TOP;
                    end
                end else if (r_row != '0) begin
                    w_row_nxt   = r_row - ADDR_WIDTH'(1);
                    w_state_nxt = S_RD;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_SH_RD: begin
                o_mem_addr_b = r_dst - ADDR_WIDTH'(1);
                w_state_nxt  = S_SH_WR;
            end
            S_SH_WR: begin
                // Write is gated by reset so an aborting reset never lands a shift.
                if (i_rst_n) begin
                    o_mem_we_a   = 1'b1;
                    o_mem_addr_a = r_dst;
                    o_mem_data_a = i_mem_q_b;
                end
                if (r_dst == ADDR_WIDTH'(1)) begin
                    w_state_nxt = S_CLR_TOP;
                end else begin
                    w_dst_nxt   = r_dst - ADDR_WIDTH'(1);
                    w_state_nxt = S_SH_RD;
                end
            end
            S_CLR_TOP: begin
                o_mem_we_a  = i_rst_n;
                w_cnt_nxt   = r_cnt + CNT_WIDTH'(1);
                w_state_nxt = S_RD;
            end
            S_DONE: begin
                o_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_line_clear_engine.sv
// Randomized bench for line_clear_engine: a grid memory model plus a row-compaction
// reference that predicts final grid, line count, write count and pass length.
module tb_line_clear_engine;
    localparam int DW   = 8;
    localparam int AW   = 8;
    localparam int ROWS = 20;
    localparam int CW   = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, we_a;
    logic [CW-1:0] lines;
    logic [AW-1:0] addr_b, addr_a;
    logic [DW-1:0] q_b, data_a;

    line_clear_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ROWS(ROWS), .CNT_WIDTH(CW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .o_busy(busy), .o_done(done), .o_lines_cleared(lines),
        .o_mem_addr_b(addr_b), .i_mem_q_b(q_b),
        .o_mem_addr_a(addr_a), .o_mem_data_a(data_a), .o_mem_we_a(we_a)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:255];
    int            wr_count = 0;
    logic [AW-1:0] last_wr_addr;
    logic [DW-1:0] last_wr_data;

    always @(posedge clk) begin
        if (we_a) begin
            mem[addr_a] <= data_a;
            wr_count = wr_count + 1;
            last_wr_addr = addr_a;
            last_wr_data = data_a;
        end
        q_b <= mem[addr_b];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Output invariants every cycle outside reset.
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (!we_a && (addr_a != 0 || data_a != 0)) begin
                errors++;
                $display("FAIL idle_write_port: addr_a=%0d data_a=%0h expected 0/0", addr_a, data_a);
            end else if (we_a && addr_a >= ROWS) begin
                errors++;
                $display("FAIL write_range: addr_a=%0d expected < %0d", addr_a, ROWS);
            end else if (done && !busy) begin
                errors++;
                $display("FAIL done_busy: done=1 busy=0 expected busy=1");
            end else if (done && prev_done) begin
                errors++;
                $display("FAIL done_pulse: done high 2 cycles expected 1");
            end
            prev_done = done;
        end
    end

    logic [DW-1:0] g_init [ROWS];
    logic [DW-1:0] g_exp  [ROWS];
    int exp_cnt, exp_cycles, exp_writes;

    task automatic model();
        logic [DW-1:0] arr [ROWS];
        int k, r;
        // Final grid: surviving rows settle to the bottom in order, zeros above.
        exp_cnt = 0;
        k = ROWS - 1;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (g_init[i] == '1) exp_cnt++;
            else begin
                g_exp[k] = g_init[i];
                k--;
            end
        end
        for (int i = k; i >= 0; i--) g_exp[i] = '0;
        // Pass length from the per-row cost rules.
        for (int i = 0; i < ROWS; i++) arr[i] = g_init[i];
        r = ROWS - 1;
        exp_cycles = 0;
        exp_writes = 0;
        forever begin
            exp_cycles += 2;
            if (arr[r] == '1) begin
                exp_cycles += (r > 0) ? 2 * r + 1 : 1;
                exp_writes += r + 1;
                for (int j = r; j > 0; j--) arr[j] = arr[j-1];
                arr[0] = '0;
            end else if (r == 0) begin
                break;
            end else begin
                r--;
            end
        end
        exp_cycles += 1;
    endtask

    task automatic load_grid();
        for (int i = 0; i < ROWS; i++) mem[i] = g_init[i];
    endtask

    task automatic run_pass(input string tag, input bit extra_start);
        int busy_cnt, done_at, bad;
        model();
        load_grid();
        wr_count = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_cnt = 0;
        done_at = 0;
        for (int c = 0; c < 3000; c++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_at = busy_cnt;
                break;
            end
            start = extra_start && (busy_cnt == 3 || busy_cnt == exp_cycles - 1);
            @(negedge clk);
        end
        start = 1'b0;
        if (done_at == 0) begin
            errors++;
            $display("FAIL %s_timeout: no done within 3000 cycles", tag);
        end
        check({tag, "_busy_cycles"}, busy_cnt, exp_cycles);
        check({tag, "_done_cycle"}, done_at, exp_cycles);
        check({tag, "_lines"}, int'(lines), exp_cnt);
        @(negedge clk);
        check({tag, "_idle_after"}, int'(busy), 0);
        check({tag, "_writes"}, wr_count, exp_writes);
        bad = 0;
        for (int i = 0; i < ROWS; i++) begin
            if (mem[i] !== g_exp[i]) begin
                if (bad == 0)
                    $display("FAIL %s_row%0d: got %0h expected %0h", tag, i, mem[i], g_exp[i]);
                bad++;
            end
        end
        check({tag, "_grid_bad_rows"}, bad, 0);
        repeat (3) @(negedge clk);
        check({tag, "_lines_hold"}, int'(lines), exp_cnt);
    endtask

    task automatic clear_init();
        for (int i = 0; i < ROWS; i++) g_init[i] = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_lines"}, int'(lines), 0);
        check({tag, "_we"}, int'(we_a), 0);
        check({tag, "_addr_a"}, int'(addr_a), 0);
        check({tag, "_addr_b"}, int'(addr_b), 0);
        check({tag, "_data_a"}, int'(data_a), 0);
    endtask

    initial begin
        bit found;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        clear_init();
        model();
        check("model_empty_cycles", exp_cycles, 41);
        run_pass("empty", 1'b0);

        clear_init();
        g_init[19] = 8'hFF;
        g_init[18] = 8'h81;
        run_pass("bottom", 1'b0);
        check("bottom_row19", int'(mem[19]), 8'h81);

        clear_init();
        for (int i = 16; i < 20; i++) g_init[i] = 8'hFF;
        g_init[15] = 8'h3C;
        model();
        check("model_four_cnt", exp_cnt, 4);
        run_pass("four", 1'b0);
        check("four_lines_lit", int'(lines), 4);
        check("four_row19", int'(mem[19]), 8'h3C);

        clear_init();
        g_init[0] = 8'hFF;
        run_pass("top", 1'b0);
        check("top_wr_count", wr_count, 1);
        check("top_wr_addr", int'(last_wr_addr), 0);
        check("top_wr_data", int'(last_wr_data), 0);
        check("top_lines_lit", int'(lines), 1);

        clear_init();
        g_init[19] = 8'hFF;
        g_init[10] = 8'hFF;
        g_init[5] = 8'h12;
        run_pass("restart", 1'b1);

        // Abort with reset during the first shift write.
        clear_init();
        g_init[19] = 8'hFF;
        g_init[18] = 8'h81;
        load_grid();
        wr_count = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (we_a && addr_a != 0) begin
                found = 1'b1;
                rst_n = 1'b0;
                break;
            end
            @(negedge clk);
        end
        check("rst_found_shwr", int'(found), 1);
        @(negedge clk);
        check_reset_outputs("rst_mid");
        check("rst_no_write", wr_count, 0);
        check("rst_row19_kept", int'(mem[19]), 8'hFF);
        rst_n = 1'b1;
        @(negedge clk);
        run_pass("post_rst", 1'b0);

        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < ROWS; i++) begin
                if ($urandom_range(0, 99) < 35) g_init[i] = 8'hFF;
                else if ($urandom_range(0, 3) == 0) g_init[i] = '0;
                else g_init[i] = DW'($urandom);
            end
            run_pass("rand", 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
